// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display sharing one registered decoder.
// Double-buffered display value, valid/ready load, frame-boundary commit, dead time between digits.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    lz_blank,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [3:0]              bcd,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick,
    output logic                    bcd_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam int MAXC = (BLANK > DWELL) ? BLANK : DWELL;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [1:0]              st, st_n;
    logic [IW-1:0]           idx, idx_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_n, pending, upper_n;
    logic                    pending_full, accept, commit, any_bad;
    logic [3:0]              nib_n;
    logic                    sup_n;

    assign value_ready = !pending_full;

    always_comb begin
        accept   = value_valid && !pending_full;
        commit   = pending_full && (frame_tick || !enable || st == S_IDLE);
        shadow_n = commit ? pending : shadow;
    end

    always_comb begin
        any_bad = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (pending[4*i +: 4] > 4'd9) any_bad = 1'b1;
        end
    end

    always_comb begin
        st_n  = st;
        idx_n = idx;
        cnt_n = cnt;
        if (!enable) begin
            st_n  = S_IDLE;
            idx_n = '0;
            cnt_n = '0;
        end else begin
            case (st)
                S_IDLE: begin
                    st_n  = S_BLANK;
                    idx_n = '0;
                    cnt_n = '0;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        st_n  = S_DRIVE;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        st_n  = S_BLANK;
                        cnt_n = '0;
                        idx_n = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    st_n  = S_IDLE;
                    idx_n = '0;
                    cnt_n = '0;
                end
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe;
    // the next shadow is used so the first digit of a new frame already shows the committed value.
    always_comb begin
        nib_n   = shadow_n[4*idx_n +: 4];
        upper_n = shadow_n >> {idx_n, 2'b00};
        sup_n   = (nib_n > 4'd9) || (lz_blank && idx_n != '0 && upper_n == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= S_IDLE;
            idx          <= '0;
            cnt          <= '0;
            shadow       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            bcd          <= '0;
            digit_en     <= '0;
            seg_out      <= '0;
            frame_tick   <= 1'b0;
            bcd_err      <= 1'b0;
        end else begin
            st     <= st_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            if (accept) begin
                pending      <= value_in;
                pending_full <= 1'b1;
            end else if (commit) begin
                pending_full <= 1'b0;
            end
            if (commit && any_bad) bcd_err <= 1'b1;
            bcd        <= (st_n == S_IDLE || nib_n > 4'd9) ? 4'd0 : nib_n;
            digit_en   <= (st_n == S_DRIVE) ? (NUM_DIGITS'(1) << idx_n) : '0;
            seg_out    <= (st_n == S_DRIVE && !sup_n) ? seg_in : '0;
            frame_tick <= (st_n == S_DRIVE) && (idx_n == IDX_LAST) && (cnt_n == DWELL_LAST);
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one registered BCD-to-7-segment decoder across NUM_DIGITS common-anode display digits.
- Holds a double-buffered display value and accepts new values through a valid/ready handshake, committing them only at frame boundaries.
- Drives the decoder's BCD input, then gates its segment output and the digit enables, with dead time between digits to prevent ghosting.
- Sits between the counter/value logic and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- DWELL, 1000, clock cycles each digit's enable is asserted (>=1).
- BLANK, 16, dead-time cycles before each digit with all enables off (>=2, covers decoder latency).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scan enable; low forces IDLE
- lz_blank  in  1  1 = suppress leading zeros
- value_in  in  4*NUM_DIGITS  new BCD digits; digit 0 = bits [3:0] (least significant)
- value_valid  in  1  value_in offered
- value_ready  out  1  controller can accept a value
- bcd  out  4  to shared decoder input
- seg_in  in  7  decoder output {g,f,e,d,c,b,a}, one-cycle registered latency
- seg_out  out  7  segment drive, active-high
- digit_en  out  NUM_DIGITS  one-hot digit enable, active-high
- frame_tick  out  1  one-cycle pulse at end of each full scan
- bcd_err  out  1  sticky; a committed digit was >9

Behaviour:
- Reset (async): FSM=IDLE; idx=0; counter=0; shadow=0; pending empty; bcd=0; digit_en=0; seg_out=0; frame_tick=0; bcd_err=0; value_ready=1.
- Handshake:
  - value_ready = !pending_full.
  - On valid&&ready, value_in is latched into the pending register and pending_full=1.
  - At a frame boundary (the cycle frame_tick=1), a full pending value is copied to the shadow register and pending_full clears; value_ready returns high the next cycle.
  - If enable=0 or FSM=IDLE, a pending value commits on the next cycle instead.
  - When a commit and valid coincide, the new value is not accepted that cycle because ready is still low.
- Sticky error: at commit, any nibble >9 sets bcd_err. bcd_err clears only on reset.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: digit_en=0, seg_out=0, idx=0. Move to BLANK when enable=1.
  - BLANK: digit_en=0, seg_out=0, bcd=shadow[idx]. Stay BLANK cycles, then move to DRIVE.
  - DRIVE: digit_en=(1<<idx), seg_out=seg_in unless the digit is suppressed (then 0). Stay DWELL cycles.
    - If idx<NUM_DIGITS-1: idx++ and go to BLANK.
    - Otherwise: idx=0, frame_tick=1 on the last DRIVE cycle, go to BLANK.
- bcd holds shadow[idx] throughout BLANK and DRIVE. Because BLANK>=2, seg_in is settled when DRIVE begins.
- Suppressed digit: nibble >9 (bcd driven 0), or lz_blank=1 and the digit is zero and all more-significant digits are zero. Digit 0 is never suppressed by lz_blank.
- Shadow updates only at a frame boundary, so a value never changes mid-frame (no tearing).
- enable falling in any state:
  - Next cycle is IDLE with digit_en=0, seg_out=0, idx=0, counter=0.
  - No frame_tick is generated.
  - The pending value is kept.
- Total frame = NUM_DIGITS*(BLANK+DWELL) cycles. Counter width is sized as clog2(max(BLANK,DWELL)+1). No wrap within a state.
- Outputs digit_en, seg_out, bcd and frame_tick are registered.

Test Plan:
- Reset mid-DRIVE with digit_en=0010 -> same-cycle digit_en=0, seg_out=0, bcd_err=0, value_ready=1; after release with enable=1, idx restarts at 0.
- NUM_DIGITS=4, DWELL=4, BLANK=2, value 0x1234, enable=1 -> each digit gets 2 blank cycles then 4 cycles with digit_en=0001,0010,0100,1000 in turn and bcd=4,3,2,1; frame_tick once every 24 cycles.
- Offer 0x5678 mid-frame -> value_ready drops next cycle; digits keep showing 1234 until frame_tick; 5678 is visible from the next frame; ready rises the cycle after commit.
- lz_blank=1, value 0x0007 -> digits 1..3 have seg_out=0 during DRIVE, digit 0 shows the decoded 7. Value 0x0000 -> only digit 0 is lit.
- Value 0x12A4 -> bcd_err=1 after commit; digit 1 is blanked with bcd=0; bcd_err stays 1 after loading 0x1111.
- enable dropped in BLANK of digit 2 -> IDLE next cycle, no frame_tick; re-enable -> scan resumes at digit 0.
